uart_rx_ctrl: RTL

Receive-side controller for the UART link.
- Generates the 16x oversample tick from the system clock and synchronises `rx`.
- Sequences start/data/stop sampling, checks framing, and buffers completed bytes in a small FIFO with a valid/ready pop interface.
- Sits between the `rx` pin and the consuming logic; replaces free-running receiver sequencing with one controlled, error-reporting block.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the UART receive path.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;
  localparam int DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO; the head entry is always visible on rd_data.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; a push on a full FIFO is accepted only alongside a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick, rx synchroniser, framing FSM and byte FIFO.
// Define UART_PARITY_EN for 8E1 framing with an even-parity check; default build is 8N1.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  logic [7:0]           div_r;
  logic                 tick_s;
  logic                 sync1_r;
  logic                 sync2_r;
  logic                 rx_prev_r;
  logic                 fall_s;
  state_t               state_r;
  state_t               state_n;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_n;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_n;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_n;
  logic                 push_s;
  logic                 ferr_s;
  logic                 perr_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 pop_s;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;
`ifdef UART_PARITY_EN
  logic                 par_bad_r;
  logic                 par_bad_n;
  logic                 parity_err_r;
`endif

  assign tick_s = (div_r == 8'(CLK_DIV - 1));
  assign fall_s = rx_prev_r & ~sync2_r;
  assign pop_s  = rx_ready & ~fifo_empty_s;

  // Free-running oversample tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r <= 8'd0;
    end else if (tick_s) begin
      div_r <= 8'd0;
    end else begin
      div_r <= div_r + 8'd1;
    end
  end

  // Two-flop synchroniser plus one delayed copy for start-edge detection; idle level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // Framing sequencer: samples mid start bit, then mid every following bit (count 15 after the re-centre).
  always_comb begin
    state_n = state_r;
    cnt_n   = tick_s ? (cnt_r + CNT_W'(1)) : cnt_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    push_s  = 1'b0;
    ferr_s  = 1'b0;
    perr_s  = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_n = par_bad_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_n = {CNT_W{1'b0}};
        idx_n = {IDX_W{1'b0}};
        if (fall_s) begin
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (tick_s && (cnt_r == CNT_W'(MID_SAMPLE))) begin
          if (sync2_r) begin
            state_n = IDLE;
          end else begin
            cnt_n   = {CNT_W{1'b0}};
            idx_n   = {IDX_W{1'b0}};
            state_n = DATA;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (tick_s && (cnt_r == CNT_W'(LAST_SAMPLE))) begin
          shift_n = {sync2_r, shift_r[DATA_BITS-1:1]};
          idx_n   = idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick_s && (cnt_r == CNT_W'(LAST_SAMPLE))) begin
          par_bad_n = ~even_parity_ok(shift_r, sync2_r);
          state_n   = STOP;
        end else begin
          state_n = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s && (cnt_r == CNT_W'(LAST_SAMPLE))) begin
          if (sync2_r) begin
`ifdef UART_PARITY_EN
            perr_s = par_bad_r;
            push_s = ~par_bad_r;
`else
            push_s = 1'b1;
`endif
            state_n = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          state_n = STOP;
        end
      end
      BREAK: begin
        cnt_n = {CNT_W{1'b0}};
        if (sync2_r) begin
          state_n = IDLE;
        end else begin
          state_n = BREAK;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and registered status/error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      frame_err_r <= ferr_s;
      overrun_r   <= push_s & fifo_full_s & ~pop_s;
      busy_r      <= (state_n != IDLE);
`ifdef UART_PARITY_EN
      par_bad_r    <= par_bad_n;
      parity_err_r <= perr_s;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (shift_r),
    .pop     (pop_s),
    .rd_data (rx_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  assign rx_valid  = ~fifo_empty_s;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
  logic unused_perr_s;
  assign unused_perr_s = perr_s;
`endif

endmodule
